// File: rtl/mem_pkg.sv
// Shared types for the CPU-side memory port: MESI encoding, line layout and agent FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    I = 2'b00,
    S = 2'b01,
    E = 2'b10,
    M = 2'b11
  } Tmesi_state;

  typedef struct packed {
    Tmesi_state  mesi;
    logic [63:0] data;
  } Tline;

  localparam int LINE_W = 66;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCESS,
    ST_WAIT_RD,
    ST_RESP,
    ST_RELEASE
  } agent_state_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous command FIFO; an entry written on push is visible at head the next cycle.
module line_cmd_fifo #(
  parameter int W     = 83,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_mem_port_agent.sv
// CPU-side requester: queues cache line commands, arbitrates for the memory slot,
// performs one line transfer per granted access and returns a response to the cache.
module cpu_mem_port_agent
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 64,
  parameter int MESI_W      = 2,
  parameter int QDEPTH      = 4,
  parameter int RD_LAT      = 1,
  parameter int MAX_BURST   = 4,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [MESI_W-1:0]        cmd_mesi,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [MESI_W-1:0]        rsp_mesi,
  output logic                     rsp_err,
  output logic                     req,
  input  logic                     gnt,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [MESI_W+DATA_W-1:0] mem_wline,
  input  logic [MESI_W+DATA_W-1:0] mem_rline
);
  localparam int LW = MESI_W + DATA_W;
  localparam int EW = 1 + ADDR_W + LW;
  localparam int TW = $clog2(GNT_TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int RW = $clog2(RD_LAT + 1);

  agent_state_t      state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic [BW-1:0]     burst_q, burst_d, burst_inc;
  logic [RW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [LW-1:0]     mem_wline_q, mem_wline_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [MESI_W-1:0] rsp_mesi_q, rsp_mesi_d;
  logic              rsp_err_q, rsp_err_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0]     fifo_head;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [LW-1:0]     head_line;

  line_cmd_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (fifo_pop),
    .wdata ({cmd_we, cmd_addr, cmd_mesi, cmd_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign head_we   = fifo_head[EW-1];
  assign head_addr = fifo_head[EW-2 -: ADDR_W];
  assign head_line = fifo_head[LW-1:0];

  assign cmd_ready = !fifo_full;
  assign req       = req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wline = mem_wline_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_mesi  = rsp_mesi_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    burst_d     = burst_q;
    rd_cnt_d    = rd_cnt_q;
    req_d       = req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wline_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mesi_d  = rsp_mesi_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    tmo_inc     = (tmo_q == TW'(GNT_TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
    burst_inc   = burst_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (!fifo_empty) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          state_d     = ST_ACCESS;
          mem_addr_d  = head_addr;
          mem_we_d    = head_we;
          mem_wline_d = head_we ? head_line : '0;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(GNT_TIMEOUT)) begin
            fifo_pop    = 1'b1;
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_mesi_d  = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (head_we) begin
          fifo_pop    = 1'b1;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          rsp_mesi_d  = '0;
        end else begin
          state_d  = ST_WAIT_RD;
          rd_cnt_d = RW'(1);
        end
      end
      ST_WAIT_RD: begin
        // The ACCESS cycle counts as the first of the RD_LAT cycles.
        if (rd_cnt_q == RW'(RD_LAT)) begin
          fifo_pop    = 1'b1;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = mem_rline[DATA_W-1:0];
          rsp_mesi_d  = mem_rline[LW-1 -: MESI_W];
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          rsp_mesi_d  = '0;
          burst_d     = burst_inc;
          if (!fifo_empty && (burst_inc < BW'(MAX_BURST)) && !rsp_err_q) begin
            state_d     = ST_ACCESS;
            mem_addr_d  = head_addr;
            mem_we_d    = head_we;
            mem_wline_d = head_we ? head_line : '0;
          end else begin
            state_d = ST_RELEASE;
            req_d   = 1'b0;
          end
        end
      end
      ST_RELEASE: begin
        // Hold off re-requesting until the arbiter's registered grant has dropped.
        req_d = 1'b0;
        if (!gnt) begin
          burst_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      burst_q     <= '0;
      rd_cnt_q    <= '0;
      req_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wline_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mesi_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      burst_q     <= burst_d;
      rd_cnt_q    <= rd_cnt_d;
      req_q       <= req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wline_q <= mem_wline_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mesi_q  <= rsp_mesi_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_port_agent.sv
// Scoreboard bench for cpu_mem_port_agent with a two-cycle-lag arbiter and RD_LAT=1 memory model.
module tb_cpu_mem_port_agent;
  import mem_pkg::*;

  typedef struct packed {
    logic        err;
    logic [1:0]  mesi;
    logic [63:0] data;
  } exp_rsp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [65:0] line;
  } exp_wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [1:0]  cmd_mesi;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_mesi;
  logic        req, gnt, gnt_d1, gnt_en;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [65:0] mem_wline, mem_rline;

  exp_rsp_t exp_q[$];
  exp_wr_t  wq[$];
  int       windows[$];
  int       n_checks = 0;
  int       n_errors = 0;
  int       we_pulses = 0;

  cpu_mem_port_agent dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_mesi  (cmd_mesi),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_mesi  (rsp_mesi),
    .rsp_err   (rsp_err),
    .req       (req),
    .gnt       (gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wline (mem_wline),
    .mem_rline (mem_rline)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] mem_f(input logic [15:0] a);
    if (a == 16'h0020) return {2'b10, 64'h1234};
    return {a[1:0], 32'hC0DE_0000, 16'h0000, a};
  endfunction

  // Arbiter with registered grant two cycles behind req; memory returns data one cycle after the address.
  always @(posedge clk) begin
    if (reset) begin
      gnt_d1 <= 1'b0;
      gnt    <= 1'b0;
    end else begin
      gnt_d1 <= req & gnt_en;
      gnt    <= gnt_d1;
    end
    mem_rline <= mem_f(mem_addr);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic we, input logic [15:0] addr, input logic [63:0] data,
                          input logic [1:0] mesi, input logic exp_err);
    int n;
    exp_rsp_t e;
    exp_wr_t  w;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mesi  = mesi;
    while (!cmd_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk("push_timeout", 1, 0);
    tick();
    cmd_valid = 1'b0;
    e.err  = exp_err;
    e.mesi = 2'b00;
    e.data = 64'h0;
    if (!exp_err && !we) {e.mesi, e.data} = mem_f(addr);
    exp_q.push_back(e);
    if (we && !exp_err) begin
      w.addr = addr;
      w.line = {mesi, data};
      wq.push_back(w);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wq.size() != 0 || req) && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) chk("idle_timeout", 1, 0);
    repeat (6) tick();
  endtask

  // Monitor: pops expectations on every response handshake and memory write pulse.
  initial begin
    exp_rsp_t e;
    exp_wr_t  w;
    int       cur_burst;
    logic     prev_req;
    cur_burst = 0;
    prev_req  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cur_burst = 0;
        prev_req  = 1'b0;
      end else begin
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {rsp_err, rsp_mesi, rsp_data}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_line", {rsp_err, rsp_mesi, rsp_data}, e);
          end
          if (req) cur_burst++;
        end
        if (mem_we) begin
          we_pulses++;
          if (wq.size() == 0) begin
            chk("unexpected_write", {mem_addr, mem_wline}, 0);
          end else begin
            w = wq.pop_front();
            chk("mem_write", {mem_addr, mem_wline}, w);
          end
        end else begin
          chk("wline_idle_zero", mem_wline, 0);
        end
        if (prev_req && !req) begin
          windows.push_back(cur_burst);
          cur_burst = 0;
        end
        prev_req = req;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, idle_rsp;
    logic [66:0] held;
    logic [1:0]  mesi_m;
    mesi_m    = M;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_mesi  = '0;
    rsp_ready = 1'b1;
    gnt_en    = 1'b1;
    repeat (3) tick();
    chk("reset_req", req, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_fields", {rsp_err, rsp_mesi, rsp_data}, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wline", mem_wline, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    tick();

    // Single write: one pulse and a single-transaction grant window.
    windows.delete();
    we_pulses = 0;
    push_cmd(1'b1, 16'h0010, 64'hDEAD_BEEF_0000_0001, mesi_m, 1'b0);
    wait_idle();
    chk("write_pulses", we_pulses, 1);
    chk("write_windows", windows.size(), 1);
    chk("write_window_len", windows.size() > 0 ? windows[0] : 0, 1);

    // Single read of an E line.
    push_cmd(1'b0, 16'h0020, 64'h0, 2'b00, 1'b0);
    wait_idle();

    // Six reads under a held grant: burst limit splits them 4 + 2.
    windows.delete();
    for (int i = 0; i < 6; i++) push_cmd(1'b0, 16'h0100 + 16'(i), 64'h0, 2'b00, 1'b0);
    wait_idle();
    chk("burst_windows", windows.size(), 2);
    chk("burst_first", windows.size() > 0 ? windows[0] : 0, 4);
    chk("burst_second", windows.size() > 1 ? windows[1] : 0, 2);

    // Grant timeout: error after exactly 255 REQ cycles, then the next command is requested.
    gnt_en = 1'b0;
    push_cmd(1'b0, 16'h0200, 64'h0, 2'b00, 1'b1);
    push_cmd(1'b1, 16'h0300, 64'h0000_0000_CAFE_0300, 2'b01, 1'b0);
    n = 0;
    k = 0;
    while (!rsp_valid && k < 600) begin
      if (req) n++;
      tick();
      k++;
    end
    chk("timeout_req_cycles", n, 255);
    chk("timeout_err_flag", rsp_err, 1);
    k = 0;
    while (req && k < 50) begin tick(); k++; end
    k = 0;
    while (!req && k < 50) begin tick(); k++; end
    chk("timeout_rerequest", req, 1);
    gnt_en = 1'b1;
    wait_idle();

    // Fill the FIFO with grant withheld; extra command must be refused.
    gnt_en = 1'b0;
    for (int i = 0; i < 4; i++)
      push_cmd(1'b1, 16'h0400 + 16'(i), 64'h5555_0000_0000_0000 | 64'(i), 2'(i), 1'b0);
    chk("full_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 16'h04FF;
    cmd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (3) tick();
    chk("full_cmd_ready_held", cmd_ready, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    gnt_en    = 1'b1;
    k = 0;
    while (!rsp_valid && k < 100) begin tick(); k++; end
    chk("stall_rsp_arrives", rsp_valid, 1);
    held = {rsp_err, rsp_mesi, rsp_data};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid_held", rsp_valid, 1);
      chk("stall_fields_stable", {rsp_err, rsp_mesi, rsp_data}, held);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Continuous stream: pushes coincide with pops while the FIFO is partly full.
    for (int i = 0; i < 10; i++)
      push_cmd(i[0], 16'h0600 + 16'(i), 64'h0123_4567_0000_0000 | 64'(i), 2'(i), 1'b0);
    wait_idle();
    chk("stream_drained_ready", cmd_ready, 1);

    // Reset while a read waits on memory: it is dropped without a response.
    push_cmd(1'b0, 16'h0700, 64'h0, 2'b00, 1'b0);
    k = 0;
    while (dut.state_q != ST_WAIT_RD && k < 100) begin tick(); k++; end
    chk("reached_wait_rd", k < 100, 1);
    reset = 1'b1;
    exp_q.delete();
    wq.delete();
    tick();
    chk("rst_wait_req", req, 0);
    chk("rst_wait_rsp_valid", rsp_valid, 0);
    chk("rst_wait_mem_we", mem_we, 0);
    chk("rst_wait_cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    idle_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || req) idle_rsp++;
    end
    chk("no_stale_activity", idle_rsp, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
